// File: rtl/invaders_mem_pkg.sv
// Shared types for the Space Invaders work/video RAM: geometry, return-pipe
// owner tags and the latched CPU request.
package invaders_mem_pkg;

    localparam int RAM_AW = 13;
    localparam int RAM_DW = 8;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_VID  = 2'd2
    } owner_t;

    typedef struct packed {
        logic [RAM_AW-1:0] addr;
        logic [RAM_DW-1:0] data;
        logic              rw_n;
    } pend_req_t;

    typedef struct packed {
        owner_t     tag1;
        owner_t     tag2;
        logic [3:0] starve_cnt;
        logic       cpu_pend;
        logic       vid_pend;
    } arb_dbg_t;

endpackage

// File: rtl/invaders_ram_arbiter.sv
// Single-port RAM arbiter: CPU (READY-stalled) and video fetcher share one
// spram; video gets priority bounded by STARVE_LIMIT consecutive grants.
module invaders_ram_arbiter
    import invaders_mem_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic              Cpu_Req,
    input  logic              Cpu_RW_n,
    input  logic [RAM_AW-1:0] Cpu_Addr,
    input  logic [RAM_DW-1:0] Cpu_Din,
    output logic [RAM_DW-1:0] Cpu_Dout,
    output logic              Cpu_Ready,
    input  logic              Vid_Req,
    input  logic [RAM_AW-1:0] Vid_Addr,
    output logic [RAM_DW-1:0] Vid_Dout,
    output logic              Vid_Valid,
    output logic              Vid_Overrun,
    output logic [RAM_AW-1:0] Ram_Addr,
    output logic [RAM_DW-1:0] Ram_Din,
    output logic              Ram_RW_n,
    input  logic [RAM_DW-1:0] Ram_Dout,
    output arb_dbg_t          Dbg_State
);

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    // Handshake: Cpu_Req/Vid_Req are single-cycle strobes that latch a request.
    // Cpu_Ready drops on the accepting edge and returns high once the write has
    // hit the RAM or the read data sits on Cpu_Dout; Vid_Valid marks Vid_Dout.
    pend_req_t         cpu_req;
    logic              cpu_pend;
    logic              vid_pend;
    logic [RAM_AW-1:0] vid_addr;
    logic [3:0]        starve_cnt;

    logic grant_vid;
    logic grant_cpu;
    logic cpu_accept;

    owner_t tag1, tag2;
    owner_t tag1_next, tag2_next;
    logic   ret_cpu, ret_vid, cpu_rd_inflight;

    always_comb begin
        grant_vid  = vid_pend && (!cpu_pend || (starve_cnt < STARVE_MAX));
        grant_cpu  = cpu_pend && !grant_vid;
        cpu_accept = Cpu_Req && !cpu_pend && !cpu_rd_inflight;
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            cpu_pend    <= 1'b0;
            cpu_req     <= '0;
            vid_pend    <= 1'b0;
            vid_addr    <= '0;
            Vid_Overrun <= 1'b0;
        end else begin
            if (cpu_accept) begin
                cpu_pend <= 1'b1;
                cpu_req  <= '{addr: Cpu_Addr, data: Cpu_Din, rw_n: Cpu_RW_n};
            end else if (grant_cpu) begin
                cpu_pend <= 1'b0;
            end
            // A fresh strobe always overwrites; only an un-issued one is lost.
            if (Vid_Req) begin
                vid_pend <= 1'b1;
                vid_addr <= Vid_Addr;
            end else if (grant_vid) begin
                vid_pend <= 1'b0;
            end
            if (Vid_Req && vid_pend && !grant_vid)
                Vid_Overrun <= 1'b1;
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n)
            starve_cnt <= '0;
        else if (grant_cpu || !cpu_pend)
            starve_cnt <= '0;
        else if (grant_vid && (starve_cnt < STARVE_MAX))
            starve_cnt <= starve_cnt + 4'd1;
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            Ram_Addr <= '0;
            Ram_Din  <= '0;
            Ram_RW_n <= 1'b1;
        end else begin
            Ram_RW_n <= !(grant_cpu && !cpu_req.rw_n);
            if (grant_vid) begin
                Ram_Addr <= vid_addr;
            end else if (grant_cpu) begin
                Ram_Addr <= cpu_req.addr;
                Ram_Din  <= cpu_req.data;
            end
        end
    end

    // Owner FSM: two tag stages track which requester owns the RAM output.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            tag1 <= OWN_NONE;
            tag2 <= OWN_NONE;
        end else begin
            tag1 <= tag1_next;
            tag2 <= tag2_next;
        end
    end

    always_comb begin
        tag1_next = OWN_NONE;
        if (grant_vid)
            tag1_next = OWN_VID;
        else if (grant_cpu && cpu_req.rw_n)
            tag1_next = OWN_CPU;
        tag2_next = tag1;
    end

    always_comb begin
        ret_cpu         = (tag2 == OWN_CPU);
        ret_vid         = (tag2 == OWN_VID);
        cpu_rd_inflight = (tag1 == OWN_CPU) || (tag2 == OWN_CPU);
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            Cpu_Dout  <= '0;
            Vid_Dout  <= '0;
            Vid_Valid <= 1'b0;
            Cpu_Ready <= 1'b1;
        end else begin
            Vid_Valid <= ret_vid;
            if (ret_vid)
                Vid_Dout <= Ram_Dout;
            if (ret_cpu)
                Cpu_Dout <= Ram_Dout;
            // Ram_RW_n low means a CPU write is landing in the RAM this edge.
            if (cpu_accept)
                Cpu_Ready <= 1'b0;
            else if (ret_cpu || !Ram_RW_n)
                Cpu_Ready <= 1'b1;
        end
    end

    assign Dbg_State = '{tag1: tag1, tag2: tag2, starve_cnt: starve_cnt,
                         cpu_pend: cpu_pend, vid_pend: vid_pend};

endmodule

// File: tb/tb_invaders_ram_arbiter.sv
// Directed bench for invaders_ram_arbiter with a behavioural spram model and
// expected-data queues for CPU and video reads.
module tb_invaders_ram_arbiter;
    import invaders_mem_pkg::*;

    logic              Clock = 1'b0;
    logic              Reset_n = 1'b0;
    logic              Cpu_Req = 1'b0;
    logic              Cpu_RW_n = 1'b1;
    logic [RAM_AW-1:0] Cpu_Addr = '0;
    logic [RAM_DW-1:0] Cpu_Din = '0;
    logic [RAM_DW-1:0] Cpu_Dout;
    logic              Cpu_Ready;
    logic              Vid_Req = 1'b0;
    logic [RAM_AW-1:0] Vid_Addr = '0;
    logic [RAM_DW-1:0] Vid_Dout;
    logic              Vid_Valid;
    logic              Vid_Overrun;
    logic [RAM_AW-1:0] Ram_Addr;
    logic [RAM_DW-1:0] Ram_Din;
    logic              Ram_RW_n;
    logic [RAM_DW-1:0] Ram_Dout = '0;
    arb_dbg_t          Dbg_State;

    int errors = 0;
    int checks = 0;
    int wr_cnt = 0;
    logic [RAM_DW-1:0] cpu_exp_q[$];
    logic [RAM_DW-1:0] vid_exp_q[$];
    logic [RAM_DW-1:0] mem [0:(1<<RAM_AW)-1];

    invaders_ram_arbiter #(.STARVE_LIMIT(4)) dut (
        .Clock(Clock), .Reset_n(Reset_n),
        .Cpu_Req(Cpu_Req), .Cpu_RW_n(Cpu_RW_n), .Cpu_Addr(Cpu_Addr), .Cpu_Din(Cpu_Din),
        .Cpu_Dout(Cpu_Dout), .Cpu_Ready(Cpu_Ready),
        .Vid_Req(Vid_Req), .Vid_Addr(Vid_Addr), .Vid_Dout(Vid_Dout),
        .Vid_Valid(Vid_Valid), .Vid_Overrun(Vid_Overrun),
        .Ram_Addr(Ram_Addr), .Ram_Din(Ram_Din), .Ram_RW_n(Ram_RW_n), .Ram_Dout(Ram_Dout),
        .Dbg_State(Dbg_State)
    );

    // Clock / reset-independent spram model: registered read, write on wren.
    always #5 Clock = ~Clock;

    always @(posedge Clock) begin
        if (Ram_RW_n == 1'b0)
            mem[Ram_Addr] <= Ram_Din;
        Ram_Dout <= mem[Ram_Addr];
    end

    always @(negedge Clock) begin
        if (Ram_RW_n === 1'b0)
            wr_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Video scoreboard: every Vid_Valid pulse consumes one expected byte.
    always @(negedge Clock) begin
        if (Reset_n && Vid_Valid) begin
            if (vid_exp_q.size() == 0)
                check("vid_unexpected", 32'(Vid_Dout), 32'hFFFF_FFFF);
            else
                check("vid_dout", 32'(Vid_Dout), 32'(vid_exp_q.pop_front()));
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cpu_ready"}, 32'(Cpu_Ready), 1);
        check({tag, "_vid_valid"}, 32'(Vid_Valid), 0);
        check({tag, "_overrun"}, 32'(Vid_Overrun), 0);
        check({tag, "_ram_rw_n"}, 32'(Ram_RW_n), 1);
        check({tag, "_ram_addr"}, 32'(Ram_Addr), 0);
        check({tag, "_ram_din"}, 32'(Ram_Din), 0);
        check({tag, "_cpu_dout"}, 32'(Cpu_Dout), 0);
        check({tag, "_vid_dout"}, 32'(Vid_Dout), 0);
    endtask

    task automatic apply_reset(input string tag);
        @(negedge Clock);
        Reset_n = 1'b0;
        Cpu_Req = 1'b0;
        Vid_Req = 1'b0;
        repeat (2) @(negedge Clock);
        check_reset_outputs(tag);
        Reset_n = 1'b1;
    endtask

    // One CPU access with no competing video traffic; data is write data or
    // the expected read data.
    task automatic cpu_access(input logic rw_n, input logic [RAM_AW-1:0] addr,
                              input logic [RAM_DW-1:0] data, input string tag);
        int lat;
        @(negedge Clock);
        Cpu_Req  = 1'b1;
        Cpu_RW_n = rw_n;
        Cpu_Addr = addr;
        Cpu_Din  = rw_n ? 8'($urandom_range(0, 255)) : data;
        if (rw_n)
            cpu_exp_q.push_back(data);
        @(negedge Clock);
        Cpu_Req = 1'b0;
        check({tag, "_busy"}, 32'(Cpu_Ready), 0);
        lat = 0;
        while (!Cpu_Ready && lat < 20) begin
            @(negedge Clock);
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), rw_n ? 3 : 2);
        if (rw_n)
            check({tag, "_dout"}, 32'(Cpu_Dout), 32'(cpu_exp_q.pop_front()));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        int lat;
        logic [RAM_AW-1:0] exp_addr [7];
        logic [RAM_AW-1:0] a;
        logic [RAM_DW-1:0] d;

        // Reset values
        repeat (2) @(negedge Clock);
        check_reset_outputs("reset");
        Reset_n = 1'b1;

        // CPU write then read-back, no video traffic
        w0 = wr_cnt;
        cpu_access(1'b0, 13'h0400, 8'h5A, "wr400");
        check("wr400_pulse", 32'(wr_cnt - w0), 1);
        check("wr400_addr", 32'(Ram_Addr), 32'h0400);
        cpu_access(1'b1, 13'h0400, 8'h5A, "rd400");

        // Video read of the top address
        cpu_access(1'b0, 13'h1FFF, 8'hC3, "pre1fff");
        @(negedge Clock);
        Vid_Req  = 1'b1;
        Vid_Addr = 13'h1FFF;
        vid_exp_q.push_back(8'hC3);
        @(negedge Clock);
        Vid_Req = 1'b0;
        lat = 0;
        while (!Vid_Valid && lat < 20) begin
            @(negedge Clock);
            lat++;
        end
        check("vid_lat", 32'(lat), 3);
        @(negedge Clock);
        check("vid_pulse_width", 32'(Vid_Valid), 0);

        // Simultaneous CPU read and video read
        cpu_access(1'b0, 13'h0010, 8'h11, "pre010");
        cpu_access(1'b0, 13'h0020, 8'h22, "pre020");
        @(negedge Clock);
        Cpu_Req = 1'b1; Cpu_RW_n = 1'b1; Cpu_Addr = 13'h0010;
        Vid_Req = 1'b1; Vid_Addr = 13'h0020;
        vid_exp_q.push_back(8'h22);
        cpu_exp_q.push_back(8'h11);
        @(negedge Clock);
        Cpu_Req = 1'b0; Vid_Req = 1'b0;
        @(negedge Clock);
        check("sim_first_addr", 32'(Ram_Addr), 32'h0020);
        @(negedge Clock);
        check("sim_second_addr", 32'(Ram_Addr), 32'h0010);
        @(negedge Clock);
        check("sim_vid_valid", 32'(Vid_Valid), 1);
        check("sim_cpu_wait", 32'(Cpu_Ready), 0);
        @(negedge Clock);
        check("sim_vid_done", 32'(Vid_Valid), 0);
        check("sim_cpu_ready", 32'(Cpu_Ready), 1);
        check("sim_cpu_dout", 32'(Cpu_Dout), 32'(cpu_exp_q.pop_front()));
        check("no_overrun", 32'(Vid_Overrun), 0);

        // Starvation bound: continuous video, one CPU read. The request at
        // 0x104 is still pending when CPU takes the slot, so 0x105 replaces it.
        cpu_access(1'b0, 13'h0030, 8'h77, "pre030");
        for (int i = 0; i < 7; i++)
            cpu_access(1'b0, 13'(13'h0100 + i), 8'(8'h40 + i), "previd");
        exp_addr = '{13'h0100, 13'h0101, 13'h0102, 13'h0103, 13'h0030, 13'h0105, 13'h0106};
        for (int k = 0; k < 10; k++) begin
            @(negedge Clock);
            if (k >= 2 && k <= 8)
                check("starve_addr", 32'(Ram_Addr), 32'(exp_addr[k-2]));
            if (k == 7)
                check("starve_cpu_wait", 32'(Cpu_Ready), 0);
            if (k == 8) begin
                check("starve_cpu_ready", 32'(Cpu_Ready), 1);
                check("starve_cpu_dout", 32'(Cpu_Dout), 32'(cpu_exp_q.pop_front()));
            end
            Cpu_Req  = (k == 0);
            Cpu_RW_n = 1'b1;
            Cpu_Addr = 13'h0030;
            if (k == 0)
                cpu_exp_q.push_back(8'h77);
            Vid_Req  = (k <= 6);
            Vid_Addr = 13'(13'h0100 + k);
            if (k <= 6 && k != 4)
                vid_exp_q.push_back(8'(8'h40 + k));
        end
        Vid_Req = 1'b0;
        repeat (4) @(negedge Clock);
        check("vid_queue_drained", 32'(vid_exp_q.size()), 0);
        check("overrun_set", 32'(Vid_Overrun), 1);
        repeat (3) @(negedge Clock);
        check("overrun_sticky", 32'(Vid_Overrun), 1);
        apply_reset("overrun_clear");

        // Reset while a CPU write is pending but not yet issued
        w0 = wr_cnt;
        @(negedge Clock);
        Cpu_Req = 1'b1; Cpu_RW_n = 1'b0; Cpu_Addr = 13'h0555; Cpu_Din = 8'hEE;
        @(negedge Clock);
        Cpu_Req = 1'b0;
        check("midrst_busy", 32'(Cpu_Ready), 0);
        Reset_n = 1'b0;
        #1;
        check("midrst_async_ready", 32'(Cpu_Ready), 1);
        repeat (2) @(negedge Clock);
        Reset_n = 1'b1;
        repeat (5) @(negedge Clock);
        check("midrst_no_write", 32'(wr_cnt - w0), 0);
        check_reset_outputs("midrst");

        // Random write/read-back pairs after recovery
        for (int i = 0; i < 4; i++) begin
            a = 13'($urandom_range(0, (1 << RAM_AW) - 1));
            d = 8'($urandom_range(0, 255));
            cpu_access(1'b0, a, d, "rnd_wr");
            cpu_access(1'b1, a, d, "rnd_rd");
        end

        repeat (2) @(negedge Clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
